// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain: STAGES-deep control/dest pipeline with bubbles, flush, load-use stall and forward select.
// Define HAZ_COUNT_EN to add saturating bubble_cnt/hazard_cnt outputs.
module pipe_ctrl_chain #(
  parameter int CTRL_W    = 7,
  parameter int DEST_W    = 4,
  parameter int STAGES    = 3,
  parameter int RF_EN_BIT = 0,
  parameter int LOAD_BIT  = 1,
  parameter int PC_REG    = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CTRL_W-1:0]        id_ctrl,
  input  logic [DEST_W-1:0]        id_dest,
  input  logic                     id_valid,
  input  logic                     stall_in,
  input  logic [STAGES-1:0]        flush_vec,
  input  logic [DEST_W-1:0]        src_a,
  input  logic [DEST_W-1:0]        src_b,
  input  logic                     src_a_used,
  input  logic                     src_b_used,
  output logic [STAGES*CTRL_W-1:0] stage_ctrl,
  output logic [STAGES*DEST_W-1:0] stage_dest,
  output logic [STAGES-1:0]        stage_valid,
  output logic [3:0]               fwd_a_sel,
  output logic [3:0]               fwd_b_sel,
  output logic                     load_use_hazard,
  output logic                     if_id_load
`ifdef HAZ_COUNT_EN
  ,
  output logic [15:0]              bubble_cnt,
  output logic [15:0]              hazard_cnt
`endif
);
  localparam logic [DEST_W-1:0] PC = DEST_W'(PC_REG);
  logic [CTRL_W-1:0] ctrl_q [STAGES];
  logic [CTRL_W-1:0] ctrl_d [STAGES];
  logic [DEST_W-1:0] dest_q [STAGES];
  logic [DEST_W-1:0] dest_d [STAGES];
  logic [STAGES-1:0] valid_q, valid_d, wr, fwd_ok;
  logic stall_any, ld0, a_hit, b_hit;
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    assign wr[g] = valid_q[g] & ctrl_q[g][RF_EN_BIT];
    // a load in stage 0 has no data yet, so it can only stall, never forward
    assign fwd_ok[g] = wr[g] & ~((g == 0) && ctrl_q[g][LOAD_BIT]);
    assign stage_ctrl[g*CTRL_W +: CTRL_W] = ctrl_q[g];
    assign stage_dest[g*DEST_W +: DEST_W] = dest_q[g];
  end
  assign stage_valid = valid_q;
  assign a_hit = src_a_used & (src_a == dest_q[0]);
  assign b_hit = src_b_used & (src_b == dest_q[0]);
  assign load_use_hazard = wr[0] & ctrl_q[0][LOAD_BIT] & (dest_q[0] != PC) & (a_hit | b_hit);
  assign stall_any = stall_in | load_use_hazard;
  assign if_id_load = ~stall_any;
  assign ld0 = ~flush_vec[0] & ~stall_any & id_valid;
  always_comb begin
    ctrl_d[0] = ld0 ? id_ctrl : '0;
    dest_d[0] = ld0 ? id_dest : '0;
    valid_d[0] = ld0;
    for (int k = 1; k < STAGES; k++) begin
      ctrl_d[k] = flush_vec[k] ? '0 : ctrl_q[k-1];
      dest_d[k] = flush_vec[k] ? '0 : dest_q[k-1];
      valid_d[k] = ~flush_vec[k] & valid_q[k-1];
    end
  end
  // scan oldest to youngest so the youngest matching writer wins
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (fwd_ok[k] && src_a_used && src_a == dest_q[k] && src_a != PC) fwd_a_sel = 4'(k + 1);
      if (fwd_ok[k] && src_b_used && src_b == dest_q[k] && src_b != PC) fwd_b_sel = 4'(k + 1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '{default: '0};
      dest_q <= '{default: '0};
      valid_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      dest_q <= dest_d;
      valid_q <= valid_d;
    end
  end
`ifdef HAZ_COUNT_EN
  logic [15:0] bubble_q, hazard_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_q <= '0;
      hazard_q <= '0;
    end else begin
      bubble_q <= bubble_q + {15'd0, stall_any & ~&bubble_q};
      hazard_q <= hazard_q + {15'd0, load_use_hazard & ~&hazard_q};
    end
  end
  assign bubble_cnt = bubble_q;
  assign hazard_cnt = hazard_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// tb_pipe_ctrl_chain: directed self-checking bench for pipe_ctrl_chain (default 3 stages, 7-bit ctrl, 4-bit dest).
module tb_pipe_ctrl_chain;
  logic clk = 0, reset = 1;
  logic [6:0] id_ctrl = '0;
  logic [3:0] id_dest = '0, src_a = '0, src_b = '0;
  logic id_valid = 0, stall_in = 0, src_a_used = 0, src_b_used = 0;
  logic [2:0] flush_vec = '0;
  logic [20:0] stage_ctrl;
  logic [11:0] stage_dest;
  logic [2:0] stage_valid;
  logic [3:0] fwd_a_sel, fwd_b_sel;
  logic load_use_hazard, if_id_load;
  int checks = 0, errors = 0;
`ifdef HAZ_COUNT_EN
  logic [15:0] bubble_cnt, hazard_cnt;
`endif
  pipe_ctrl_chain dut (
    .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_dest(id_dest), .id_valid(id_valid),
    .stall_in(stall_in), .flush_vec(flush_vec), .src_a(src_a), .src_b(src_b),
    .src_a_used(src_a_used), .src_b_used(src_b_used), .stage_ctrl(stage_ctrl),
    .stage_dest(stage_dest), .stage_valid(stage_valid), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .load_use_hazard(load_use_hazard), .if_id_load(if_id_load)
`ifdef HAZ_COUNT_EN
    , .bubble_cnt(bubble_cnt), .hazard_cnt(hazard_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [6:0] c, input logic [3:0] d);
    id_ctrl = c; id_dest = d; id_valid = 1;
    tick();
  endtask
  task automatic do_reset();
    reset = 1; stall_in = 0; flush_vec = '0; id_valid = 0;
    src_a_used = 0; src_b_used = 0;
    tick();
    reset = 0;
  endtask
  initial begin
    id_valid = 1; id_ctrl = 7'h11; id_dest = 4'd5;
    tick(); tick();
    chk("reset_ctrl", 32'(stage_ctrl), 0);
    chk("reset_dest", 32'(stage_dest), 0);
    chk("reset_valid", 32'(stage_valid), 0);
    chk("reset_ifid", 32'(if_id_load), 1);
    reset = 0;
    push(7'b0010001, 4'd5);
    id_valid = 0;
    chk("lat_s0", 32'({stage_valid[0], stage_dest[3:0], stage_ctrl[6:0]}), {20'd0, 1'b1, 4'd5, 7'h11});
    tick();
    chk("lat_s2_early", 32'(stage_valid), 32'(3'b010));
    tick();
    chk("lat_s2", 32'({stage_valid, stage_dest[11:8], stage_ctrl[20:14]}), {20'd0, 3'b100, 4'd5, 7'h11});
    // invalid ID loads a bubble even with nonzero fields
    do_reset();
    id_valid = 0; id_ctrl = 7'h01; id_dest = 4'd7;
    tick();
    chk("invalid_bubble", 32'({stage_valid[0], stage_dest[3:0], stage_ctrl[6:0]}), 0);
    // forwarding distance 1, 2, 3
    do_reset();
    push(7'h01, 4'd5);
    push(7'h00, 4'd0);
    chk("fwd_dist0_pre", 32'(stage_valid), 32'(3'b011));
    do_reset();
    push(7'h01, 4'd5);
    id_ctrl = 7'h00; id_dest = 4'd0; src_a = 4'd5; src_a_used = 1; src_b = 4'd6; src_b_used = 1;
    #1;
    chk("fwd_a_1", 32'(fwd_a_sel), 1);
    chk("fwd_b_none", 32'(fwd_b_sel), 0);
    chk("alu_no_hazard", 32'(load_use_hazard), 0);
    tick();
    chk("fwd_a_2", 32'(fwd_a_sel), 2);
    tick();
    chk("fwd_a_3", 32'(fwd_a_sel), 3);
    do_reset();
    src_a = 4'd5; src_a_used = 1;
    push(7'h01, 4'd5);
    push(7'h01, 4'd5);
    chk("fwd_youngest", 32'(fwd_a_sel), 1);
    // load-use hazard on src_b
    do_reset();
    src_b = 4'd3; src_b_used = 0;
    push(7'h03, 4'd3);
    id_ctrl = 7'h00; id_dest = 4'd0; src_b_used = 1;
    #1;
    chk("lu_hazard", 32'(load_use_hazard), 1);
    chk("lu_ifid", 32'(if_id_load), 0);
    chk("lu_no_fwd_s0", 32'(fwd_b_sel), 0);
    tick();
    chk("lu_s0_bubble", 32'({stage_valid[0], stage_ctrl[6:0]}), 0);
    chk("lu_s1_load", 32'({stage_valid[1], stage_dest[7:4], stage_ctrl[13:7]}), {20'd0, 1'b1, 4'd3, 7'h03});
    chk("lu_cleared", 32'(load_use_hazard), 0);
    chk("lu_fwd_b_2", 32'(fwd_b_sel), 2);
    chk("lu_ifid_back", 32'(if_id_load), 1);
    // unused source and PC register never match
    do_reset();
    src_b = 4'd3; src_b_used = 0;
    push(7'h03, 4'd3);
    chk("unused_no_hazard", 32'(load_use_hazard), 0);
    do_reset();
    src_a = 4'd15; src_a_used = 1;
    push(7'h01, 4'd15);
    chk("pc_no_fwd", 32'(fwd_a_sel), 0);
    do_reset();
    src_a = 4'd15; src_a_used = 1;
    push(7'h03, 4'd15);
    chk("pc_no_hazard", 32'(load_use_hazard), 0);
    src_a_used = 0;
    // flush with stall
    do_reset();
    push(7'h01, 4'd1);
    push(7'h05, 4'd2);
    flush_vec = 3'b011; stall_in = 1;
    #1;
    chk("stall_ifid", 32'(if_id_load), 0);
    tick();
    chk("flush_valid", 32'(stage_valid), 32'(3'b100));
    chk("flush_ctrl", 32'(stage_ctrl), 32'({7'h01, 7'h00, 7'h00}));
    chk("flush_dest", 32'(stage_dest), 32'({4'd1, 4'd0, 4'd0}));
    flush_vec = '0; stall_in = 0;
    push(7'h05, 4'd2);
    reset = 1; flush_vec = 3'b100;
    tick();
    chk("midreset_all", 32'({stage_valid, stage_ctrl}), 0);
    chk("midreset_dest", 32'(stage_dest), 0);
    // three stalled cycles insert three bubbles
    do_reset();
    stall_in = 1; id_valid = 1; id_ctrl = 7'h01; id_dest = 4'd4;
    tick(); tick(); tick();
    chk("stall_bubbles", 32'(stage_valid), 0);
`ifdef HAZ_COUNT_EN
    chk("bubble_cnt", 32'(bubble_cnt), 3);
    chk("hazard_cnt", 32'(hazard_cnt), 0);
`endif
    stall_in = 0;
    tick();
    chk("stall_release", 32'(stage_valid), 32'(3'b001));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_chain.md
Name: pipe_ctrl_chain

Overview:
- Parametrised pipeline register chain for control/destination fields. Replaces the fixed ID_EX/EX_MEM/MEM_WB control registers with one block of STAGES stages (default 3: EX, MEM, WB).
- Adds per-stage valid bits, bubble insertion on stall, per-stage flush, load-use hazard detection and forwarding-source selection.
- Sits between control_unit and the datapath pipeline registers; the hazard unit consumes its outputs.

Parameters:
- CTRL_W, 7, width of control word per stage (matches C_U_out).
- DEST_W, 4, width of destination register field (Rd, bits 15:12).
- STAGES, 3, number of stages after ID; legal range 2..8.
- RF_EN_BIT, 0, index of RF-enable bit within control word.
- LOAD_BIT, 1, index of load-instruction bit within control word.
- PC_REG, 15, register number never forwarded or hazard-matched.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- id_ctrl  in  CTRL_W  control word from ID stage.
- id_dest  in  DEST_W  destination register from ID.
- id_valid  in  1  ID holds a real instruction.
- stall_in  in  1  external stall request.
- flush_vec  in  STAGES  bit k kills the value entering stage k this cycle.
- src_a, src_b  in  DEST_W  ID source registers (Rn, Rm).
- src_a_used, src_b_used  in  1  source actually read by the ID instruction.
- stage_ctrl  out  STAGES*CTRL_W  registered control word, stage k at [k*CTRL_W +: CTRL_W].
- stage_dest  out  STAGES*DEST_W  registered destination per stage.
- stage_valid  out  STAGES  registered valid per stage.
- fwd_a_sel, fwd_b_sel  out  4  0 means no forward; k+1 means forward from stage k.
- load_use_hazard  out  1  combinational; high when ID must stall.
- if_id_load  out  1  ~(stall_in | load_use_hazard); drives IF_ID_Load and PC_RF_ld.

Behaviour:
- Reset (synchronous): on a clk edge with reset=1, all stage_ctrl, stage_dest and stage_valid become 0. It overrides flush and stall and may assert mid-stream; the stage contents are discarded.
- Bubble: ctrl=0, dest=0, valid=0.
- Entry priority at each edge, per stage k:
  - flush_vec[k] → bubble.
  - else if k==0 and (stall_in | load_use_hazard) → bubble.
  - else if k==0 → {id_ctrl, id_dest, id_valid}; a field with id_valid=0 is loaded as a bubble.
  - else → copy of stage k-1.
- Stages ≥1 always advance. A stall freezes only IF/ID (via if_id_load) and inserts one bubble into stage 0 per stalled cycle.
- Latency: an ID value appears on stage k outputs k+1 clocks after sampling.
- Stage k is a writer when stage_valid[k] & stage_ctrl[k][RF_EN_BIT].
- Load-use hazard (combinational) requires all of:
  - stage 0 is a writer;
  - stage_ctrl[0][LOAD_BIT]=1;
  - stage_dest[0] != PC_REG;
  - (src_a_used & src_a==stage_dest[0]) | (src_b_used & src_b==stage_dest[0]).
- The hazard clears automatically the next cycle, because the load advances to stage 1 and a bubble enters stage 0.
- Forwarding (combinational, per source):
  - fwd_x_sel = k+1 for the lowest k (youngest) where stage k is a writer, stage_dest[k]==src_x, src_x_used=1 and src_x!=PC_REG.
  - Stage 0 is excluded when its LOAD_BIT is set.
  - Result is 0 if no stage matches.
- Flush of a stage does not affect hazard/forward outputs until the following cycle, since outputs depend only on registered state.

Optional Feature:
- Macro HAZ_COUNT_EN.
- Defined: adds output bubble_cnt (16) and output hazard_cnt (16).
  - bubble_cnt increments on each edge where stage 0 loads a bubble due to stall or hazard.
  - hazard_cnt increments on each edge where load_use_hazard=1.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with stall_in=0 and id_valid=1 for 2 cycles → all stage outputs 0, if_id_load=1. Release; ctrl 7'b0010001 / dest 5 reaches stage 2 exactly 3 edges after sampling.
- ALU writer R5 then reader src_a=5 → fwd_a_sel=1. One cycle later (one independent instruction between) → fwd_a_sel=2. Both stage 0 and stage 1 writing R5 → 1 (youngest wins).
- Load R3 in stage 0 (ctrl LOAD+RF set), ID src_b=3 used → load_use_hazard=1, if_id_load=0. Next edge: stage 0 bubble, stage 1 the load, hazard=0, fwd_b_sel=2.
- Load R3 in stage 0 with src_b=3 but src_b_used=0 → no hazard. Writer R15 with src_a=15 → fwd_a_sel=0, no hazard.
- flush_vec=3'b011 with stall_in=1 → stages 0 and 1 become bubbles, stage 2 receives the old stage 1. Reset asserted mid-stream with flush → all zero.
- With HAZ_COUNT_EN: 3 stalled cycles → bubble_cnt=3. Preload hazard_cnt to 16'hFFFE, then 2 hazards → 16'hFFFF held.
